memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_if.sv | 39 +++
 rtl/memory_access.sv | 83 ++++++++
 tb/tb_memory_access.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// Bundles the EX/MEM slot entering the memory stage and the MEM/WB slot leaving it.
// Signal names match the memory_access stage ports one for one.
// slave: the memory stage (consumes EX/MEM, produces MEM/WB); master: the surrounding pipeline.
interface memory_access_if;
    // EX/MEM slot
    logic        enable;
    logic        valid_in;
    logic [31:0] alu_in;
    logic [31:0] store_data;
    logic        ctr_mem_read;
    logic        ctr_mem_write;
    logic        ctr_mem_to_reg_in;
    logic        ctr_reg_write_in;
    logic [4:0]  rd_in;
    // MEM/WB slot and status
    logic [31:0] datamem;
    logic [31:0] alu;
    logic        ctr_mem_to_reg;
    logic        ctr_reg_write;
    logic [4:0]  rd_out;
    logic        valid_out;
    logic        fault;
    logic [15:0] load_count;
    logic [15:0] store_count;

    modport slave (
        input  enable, valid_in, alu_in, store_data, ctr_mem_read, ctr_mem_write,
               ctr_mem_to_reg_in, ctr_reg_write_in, rd_in,
        output datamem, alu, ctr_mem_to_reg, ctr_reg_write, rd_out, valid_out,
               fault, load_count, store_count
    );

    modport master (
        output enable, valid_in, alu_in, store_data, ctr_mem_read, ctr_mem_write,
               ctr_mem_to_reg_in, ctr_reg_write_in, rd_in,
        input  datamem, alu, ctr_mem_to_reg, ctr_reg_write, rd_out, valid_out,
               fault, load_count, store_count
    );
endinterface

// File: rtl/memory_access.sv
// Pipeline memory stage: word-addressed data RAM, EX/MEM -> MEM/WB register, fault flag, access counters.
// Latency: exactly 1 cycle from an enabled edge to the MEM/WB outputs.
// Backpressure: enable=0 stalls the stage; every output, counter, the fault flag and the RAM are held.
// Ports: clk, reset (async, active-low), bus (memory_access_if.slave carrying both pipeline slots).
module memory_access #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic             clk,
    input  logic             reset,
    memory_access_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  addr_legal;
    logic                  is_access;
    logic                  is_fault;
    logic                  legal_load;
    logic                  legal_store;

    always_comb begin
        idx        = bus.alu_in[DEPTH_LOG2+1:2];
        // Word aligned and no address bits above the array.
        addr_legal = (bus.alu_in[1:0] == 2'b00) &&
                     ((bus.alu_in >> (DEPTH_LOG2 + 2)) == 32'd0);
        is_access  = bus.ctr_mem_read | bus.ctr_mem_write;
        // Read and write together is treated as malformed, same as a bad address.
        is_fault   = bus.valid_in && is_access &&
                     (!addr_legal || (bus.ctr_mem_read && bus.ctr_mem_write));
        legal_load  = bus.valid_in && bus.ctr_mem_read && !bus.ctr_mem_write && addr_legal;
        legal_store = bus.valid_in && bus.ctr_mem_write && !bus.ctr_mem_read && addr_legal;
    end

    // The RAM has no reset; a store is dropped if reset is low at the edge so
    // an in-flight slot never lands while the stage is being cleared.
    always_ff @(posedge clk) begin
        if (bus.enable && legal_store && reset) begin
            mem[idx] <= bus.store_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.datamem        <= 32'd0;
            bus.alu            <= 32'd0;
            bus.ctr_mem_to_reg <= 1'b0;
            bus.ctr_reg_write  <= 1'b0;
            bus.rd_out         <= 5'd0;
            bus.valid_out      <= 1'b0;
            bus.fault          <= 1'b0;
            bus.load_count     <= 16'd0;
            bus.store_count    <= 16'd0;
        end else if (bus.enable) begin
            bus.valid_out <= bus.valid_in;
            if (!bus.valid_in) begin
                // Bubble: nothing from the empty slot leaks downstream.
                bus.datamem        <= 32'd0;
                bus.alu            <= 32'd0;
                bus.ctr_mem_to_reg <= 1'b0;
                bus.ctr_reg_write  <= 1'b0;
                bus.rd_out         <= 5'd0;
            end else begin
                // Nonblocking read returns the word as it was before any same-edge store.
                bus.datamem        <= legal_load ? mem[idx] : 32'd0;
                bus.alu            <= bus.alu_in;
                bus.ctr_mem_to_reg <= bus.ctr_mem_to_reg_in;
                bus.ctr_reg_write  <= bus.ctr_reg_write_in && !is_fault;
                bus.rd_out         <= bus.rd_in;
            end
            if (is_fault) begin
                bus.fault <= 1'b1;
            end
            if (legal_load && (bus.load_count != 16'hFFFF)) begin
                bus.load_count <= bus.load_count + 16'd1;
            end
            if (legal_store && (bus.store_count != 16'hFFFF)) begin
                bus.store_count <= bus.store_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    memory_access_if bus();

    memory_access #(.DEPTH_LOG2(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic rd_en, input logic wr_en,
                         input logic m2r, input logic rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd);
        bus.valid_in          = vld;
        bus.ctr_mem_read      = rd_en;
        bus.ctr_mem_write     = wr_en;
        bus.ctr_mem_to_reg_in = m2r;
        bus.ctr_reg_write_in  = rw;
        bus.alu_in            = addr;
        bus.store_data        = data;
        bus.rd_in             = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " datamem"},     bus.datamem, 32'd0);
        check({tag, " alu"},         bus.alu, 32'd0);
        check({tag, " rd_out"},      {27'd0, bus.rd_out}, 32'd0);
        check({tag, " mem_to_reg"},  {31'd0, bus.ctr_mem_to_reg}, 32'd0);
        check({tag, " reg_write"},   {31'd0, bus.ctr_reg_write}, 32'd0);
        check({tag, " valid_out"},   {31'd0, bus.valid_out}, 32'd0);
        check({tag, " fault"},       {31'd0, bus.fault}, 32'd0);
        check({tag, " load_count"},  {16'd0, bus.load_count}, 32'd0);
        check({tag, " store_count"}, {16'd0, bus.store_count}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        bus.enable   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);

        // Reset state, before any clock edge.
        #2;
        check_all_zero("reset");
        tick();
        reset = 1'b1;

        // Store DEADBEEF at 0x10, CAFEF00D at 0x0.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        tick();
        check("st valid_out", {31'd0, bus.valid_out}, 32'd1);
        check("st datamem", bus.datamem, 32'd0);
        check("st store_count", {16'd0, bus.store_count}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 5'd0);
        tick();
        check("st2 store_count", {16'd0, bus.store_count}, 32'd2);

        // Load 0x10.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 5'd7);
        tick();
        check("ld datamem", bus.datamem, 32'hDEADBEEF);
        check("ld mem_to_reg", {31'd0, bus.ctr_mem_to_reg}, 32'd1);
        check("ld valid_out", {31'd0, bus.valid_out}, 32'd1);
        check("ld reg_write", {31'd0, bus.ctr_reg_write}, 32'd1);
        check("ld rd_out", {27'd0, bus.rd_out}, 32'd7);
        check("ld load_count", {16'd0, bus.load_count}, 32'd1);
        check("ld store_count", {16'd0, bus.store_count}, 32'd2);

        // ALU pass-through.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 32'd0, 5'd5);
        tick();
        check("alu alu", bus.alu, 32'h33333333);
        check("alu rd_out", {27'd0, bus.rd_out}, 32'd5);
        check("alu datamem", bus.datamem, 32'd0);
        check("alu mem_to_reg", {31'd0, bus.ctr_mem_to_reg}, 32'd0);

        // Stall three cycles with a store to 0x10 presented.
        bus.enable = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h12345678, 5'd9);
        for (int i = 0; i < 3; i++) tick();
        check("stall alu", bus.alu, 32'h33333333);
        check("stall rd_out", {27'd0, bus.rd_out}, 32'd5);
        check("stall store_count", {16'd0, bus.store_count}, 32'd2);
        check("stall load_count", {16'd0, bus.load_count}, 32'd1);
        bus.enable = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 5'd7);
        tick();
        check("stall word", bus.datamem, 32'hDEADBEEF);
        check("stall ld count", {16'd0, bus.load_count}, 32'd2);
        check("fault clear", {31'd0, bus.fault}, 32'd0);

        // Misaligned load at 0x13.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'd0, 5'd3);
        tick();
        check("mis fault", {31'd0, bus.fault}, 32'd1);
        check("mis reg_write", {31'd0, bus.ctr_reg_write}, 32'd0);
        check("mis datamem", bus.datamem, 32'd0);
        check("mis alu", bus.alu, 32'h13);
        check("mis rd_out", {27'd0, bus.rd_out}, 32'd3);
        check("mis valid_out", {31'd0, bus.valid_out}, 32'd1);
        check("mis load_count", {16'd0, bus.load_count}, 32'd2);

        // Out-of-range store at 0x400 (would alias word 0 if range were ignored).
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 5'd4);
        tick();
        check("oor fault", {31'd0, bus.fault}, 32'd1);
        check("oor reg_write", {31'd0, bus.ctr_reg_write}, 32'd0);
        check("oor store_count", {16'd0, bus.store_count}, 32'd2);

        // Misaligned store into word 0x10, then read+write conflict on 0x10.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12, 32'h11111111, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h22222222, 5'd6);
        tick();
        check("rw datamem", bus.datamem, 32'd0);
        check("rw reg_write", {31'd0, bus.ctr_reg_write}, 32'd0);
        check("rw counts", {bus.load_count, bus.store_count}, {16'd2, 16'd2});

        // Targets untouched.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'd0, 5'd1);
        tick();
        check("word0 intact", bus.datamem, 32'hCAFEF00D);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 5'd1);
        tick();
        check("word10 intact", bus.datamem, 32'hDEADBEEF);
        check("ld count 4", {16'd0, bus.load_count}, 32'd4);

        // Same-edge read-before-write is not exercisable (read+write faults); check store->load next edge at top word.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3FC, 32'h0BADC0DE, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3FC, 32'd0, 5'd2);
        tick();
        check("top word", bus.datamem, 32'h0BADC0DE);

        // Bubble with a legal load on the other inputs.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h5, 5'd8);
        tick();
        check("bub valid_out", {31'd0, bus.valid_out}, 32'd0);
        check("bub datamem", bus.datamem, 32'd0);
        check("bub alu", bus.alu, 32'd0);
        check("bub rd_out", {27'd0, bus.rd_out}, 32'd0);
        check("bub ctrl", {30'd0, bus.ctr_mem_to_reg, bus.ctr_reg_write}, 32'd0);
        check("bub load_count", {16'd0, bus.load_count}, 32'd5);

        // Saturation: 65540 more legal loads.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 5'd7);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        check("sat load_count", {16'd0, bus.load_count}, 32'h0000FFFF);
        check("sat store_count", {16'd0, bus.store_count}, 32'd3);
        check("sat fault sticky", {31'd0, bus.fault}, 32'd1);
        check("sat datamem", bus.datamem, 32'hDEADBEEF);

        // Asynchronous reset between edges after a load.
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("areset");
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hA5A5A5A5, 5'd0);
        reset = 1'b1;
        tick();
        check("resume store_count", {16'd0, bus.store_count}, 32'd1);
        check("resume valid_out", {31'd0, bus.valid_out}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'd0, 5'd10);
        tick();
        check("resume datamem", bus.datamem, 32'hA5A5A5A5);
        check("resume load_count", {16'd0, bus.load_count}, 32'd1);
        check("resume fault", {31'd0, bus.fault}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
